// File: rtl/sorted_table_writer_if.sv
// Insert handshake and RAM port bundle for sorted_table_writer.
// The slave modport is the writer itself; master is whoever feeds values and hosts the RAM.
interface sorted_table_writer_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_data, mem_rdata,
        output in_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output in_valid, in_data, mem_rdata,
        input  in_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/sorted_table_writer.sv
// Insertion-sort writer for the ascending lookup table: scans from the top entry down,
// shifting larger entries up one slot through a single-port RAM with RD_LAT read latency.
module sorted_table_writer #(
    parameter int DW     = 8,
    parameter int AW     = 4,
    parameter int RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    sorted_table_writer_if.slave   bus,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH = 1 << AW;
    localparam int WCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CMP,
        SHIFT,
        PLACE,
        FIN
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [DW-1:0]  val;
    logic [DW-1:0]  sreg;
    logic [AW-1:0]  idx;
    logic [AW-1:0]  pos;
    logic [WCW-1:0] wcnt;
    logic           xfer;
    logic [AW-1:0]  mem_addr;
    logic           mem_we;
    logic [DW-1:0]  mem_wdata;

    assign full         = (count == (AW+1)'(DEPTH));
    assign busy         = (state != IDLE);
    assign done         = (state == FIN);
    assign bus.in_ready = (state == IDLE) && !full && !clear;
    assign xfer         = bus.in_valid && bus.in_ready;

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // The RAM address is held at idx through CMP so the read pipeline still returns that entry.
    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (xfer)
                    state_next = (count == '0) ? PLACE : READ;
            end
            READ: begin
                mem_addr   = idx;
                state_next = WAIT;
            end
            WAIT: begin
                mem_addr = idx;
                if (wcnt == '0)
                    state_next = CMP;
            end
            CMP: begin
                mem_addr   = idx;
                state_next = (bus.mem_rdata > val) ? SHIFT : PLACE;
            end
            SHIFT: begin
                mem_addr   = idx + 1'b1;
                mem_wdata  = sreg;
                mem_we     = 1'b1;
                state_next = (idx == '0) ? PLACE : READ;
            end
            PLACE: begin
                mem_addr   = pos;
                mem_wdata  = val;
                mem_we     = 1'b1;
                state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clear and a transfer never coincide because in_ready is gated by clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            val   <= '0;
            sreg  <= '0;
            idx   <= '0;
            pos   <= '0;
            wcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        count <= '0;
                    end else if (xfer) begin
                        val <= bus.in_data;
                        if (count == '0)
                            pos <= '0;
                        else
                            idx <= AW'(count - 1'b1);
                    end
                end
                READ: begin
                    wcnt <= WCW'(RD_LAT - 1);
                end
                WAIT: begin
                    if (wcnt != '0)
                        wcnt <= wcnt - 1'b1;
                end
                CMP: begin
                    if (bus.mem_rdata > val)
                        sreg <= bus.mem_rdata;
                    else
                        pos <= idx + 1'b1;
                end
                SHIFT: begin
                    if (idx == '0)
                        pos <= '0;
                    else
                        idx <= idx - 1'b1;
                end
                PLACE: begin
                    count <= count + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_table_writer.sv
// Bench for sorted_table_writer: RAM model with 2-stage read, expected-result queue popped on
// every done, and a sorted multiset model of the table contents.
module tb_sorted_table_writer;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          busy;
    logic          done;

    sorted_table_writer_if #(.DW(DW), .AW(AW)) bus ();

    sorted_table_writer #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus.slave),
        .count (count),
        .full  (full),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          clr;
        logic [7:0]  data;
        int          cnt;
        int          lat;
        int          we;
        int          pos;
    } vec_t;

    typedef struct {
        int cnt;
        int lat;
        int we;
        int pos;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_q[$];
    logic [7:0] ram [DEPTH];
    logic [7:0] rd_pipe;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int xfer_cyc    = 0;
    int we_cnt      = 0;
    int last_waddr  = 0;
    int xfers       = 0;
    int dones       = 0;

    // Registered RAM: address captured, then one more output stage, so data lags by RD_LAT.
    always @(posedge clk) begin
        if (bus.mem_we)
            ram[bus.mem_addr] <= bus.mem_wdata;
        rd_pipe       <= ram[bus.mem_addr];
        bus.mem_rdata <= rd_pipe;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   ok;
        if (rst_n) begin
            if (bus.mem_we) begin
                we_cnt++;
                last_waddr = int'(bus.mem_addr);
            end
            if (bus.in_valid && bus.in_ready) begin
                xfer_cyc = cyc;
                we_cnt   = 0;
                xfers++;
            end
            if (done) begin
                dones++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("count_at_done", count, e.cnt);
                    checkOutput("latency", cyc - xfer_cyc, e.lat);
                    checkOutput("we_pulses", we_cnt, e.we);
                    checkOutput("place_addr", last_waddr, e.pos);
                    ok = 1;
                    for (int i = 0; i < model_q.size(); i++)
                        if (ram[i] !== model_q[i]) ok = 0;
                    for (int i = 1; i < int'(count); i++)
                        if (ram[i-1] > ram[i]) ok = 0;
                    checkOutput("table_contents", ok, 1);
                end
            end
        end
    end

    task automatic waitDone(input int budget);
        int target;
        int n;
        target = dones + 1;
        n      = 0;
        while (dones < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_seen", (dones >= target), 1);
        if (dones < target)
            sb_q.delete();
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int cnt, input int lat,
                                 input int we, input int pos, input bit clr_pulse);
        exp_t e;
        e.cnt = cnt;
        e.lat = lat;
        e.we  = we;
        e.pos = pos;
        sb_q.push_back(e);
        model_q.push_back(data);
        model_q.sort();
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (clr_pulse) begin
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
        end
        waitDone(400);
    endtask

    // Expected timing from the documented formula, using the bench's own sorted model.
    task automatic insertModel(input logic [7:0] data, input bit clr_pulse);
        int n;
        int k;
        int lat;
        n = model_q.size();
        k = 0;
        foreach (model_q[i])
            if (model_q[i] > data) k++;
        if (n == 0)
            lat = 2;
        else if (k == n)
            lat = k * (RD_LAT + 3) + 2;
        else
            lat = (k + 1) * (RD_LAT + 2) + k + 2;
        applyStimulus(data, n + 1, lat, k + 1, n - k, clr_pulse);
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_q.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [9];
        int   snap;

        vecs[0] = '{1'b1, 8'h05, 1,  2, 1, 0};
        vecs[1] = '{1'b1, 8'd40, 1,  2, 1, 0};
        vecs[2] = '{1'b0, 8'd10, 2,  7, 2, 0};
        vecs[3] = '{1'b0, 8'd30, 3, 11, 2, 1};
        vecs[4] = '{1'b0, 8'd20, 4, 16, 3, 1};
        vecs[5] = '{1'b1, 8'd10, 1,  2, 1, 0};
        vecs[6] = '{1'b0, 8'd20, 2,  6, 1, 1};
        vecs[7] = '{1'b0, 8'd30, 3,  6, 1, 2};
        vecs[8] = '{1'b0, 8'd20, 4, 11, 2, 2};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_count", count, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_mem_we", bus.mem_we, 0);
        checkOutput("reset_mem_addr", bus.mem_addr, 0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].clr)
                doClear();
            applyStimulus(vecs[i].data, vecs[i].cnt, vecs[i].lat, vecs[i].we, vecs[i].pos, 1'b0);
            if (i == 4)
                checkOutput("ram_after_4_inserts", {ram[0], ram[1], ram[2], ram[3]}, 32'h0A141E28);
        end
        checkOutput("ram_equal_insert", {ram[0], ram[1], ram[2], ram[3]}, 32'h0A14141E);

        doClear();
        for (int v = 1; v <= 14; v++)
            insertModel(8'(v), 1'b0);
        insertModel(8'd255, 1'b0);
        insertModel(8'd0, 1'b0);
        checkOutput("ram_extremes", {ram[0], ram[15]}, 16'h00FF);
        checkOutput("full_flag", full, 1);
        checkOutput("full_in_ready", bus.in_ready, 0);
        snap         = xfers;
        bus.in_data  = 8'h33;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        checkOutput("full_no_transfer", xfers, snap);
        checkOutput("full_count_held", count, 16);

        doClear();
        checkOutput("cleared_count", count, 0);
        checkOutput("cleared_full", full, 0);
        insertModel(8'd3, 1'b0);
        insertModel(8'd9, 1'b0);
        snap         = xfers;
        clear        = 1'b1;
        bus.in_data  = 8'h44;
        bus.in_valid = 1'b1;
        #1;
        checkOutput("clear_blocks_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        model_q.delete();
        checkOutput("clear_priority_count", count, 0);
        checkOutput("clear_priority_busy", busy, 0);
        checkOutput("clear_priority_no_xfer", xfers, snap);
        insertModel(8'd5, 1'b0);
        insertModel(8'd6, 1'b0);
        insertModel(8'd7, 1'b0);
        insertModel(8'd1, 1'b1);
        @(posedge clk); #1;
        checkOutput("busy_clear_ignored", count, 4);

        doClear();
        for (int v = 1; v <= 5; v++)
            insertModel(8'(v * 10), 1'b0);
        bus.in_data  = 8'd5;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (bus.mem_we && busy)
                break;
            @(posedge clk); #1;
        end
        checkOutput("shift_reached", bus.mem_we, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count", count, 0);
        checkOutput("abort_mem_we", bus.mem_we, 0);
        checkOutput("abort_done", done, 0);
        rst_n = 1'b1;
        model_q.delete();
        sb_q.delete();
        @(posedge clk); #1;
        insertModel(8'd7, 1'b0);
        checkOutput("post_abort_ram0", ram[0], 8'd7);
        checkOutput("post_abort_count", count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
